// File: rtl/sm_rom_loader.sv
// sm_rom_loader: parses host load frames and writes 32-bit instruction words into a node memory.
// Latency: a word write strobes one cycle after its 4th byte is accepted; load_done follows the DONE cycle.
// Backpressure: in_ready is high every cycle except the single DONE cycle; one byte per cycle otherwise.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte and the CSUM state).
module sm_rom_loader #(
  parameter int SIZE   = 128,
  parameter int ADDR_W = 7,
  parameter int NODES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [3:0]        mem_node,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cores_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [7:0]  HDR_BYTE = 8'hA5;
  // Widened limits so the comparisons stay width-matched.
  localparam logic [8:0]  NODES_L  = 9'(NODES);
  localparam logic [16:0] SIZE_L   = 17'(SIZE);

  typedef enum logic [2:0] {
    IDLE,
    NODE,
    CNT_LO,
    CNT_HI,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  // State entered once the payload (possibly empty) has been consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = CSUM;
`else
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t              state;
  logic [7:0]          cnt_lo;     // low byte of the word count, held until CNT_HI
  logic [15:0]         word_tgt;   // word count of the frame being loaded
  logic [15:0]         word_cnt;   // words written so far in this frame
  logic [1:0]          byte_cnt;   // byte position inside the current word
  logic [23:0]         wbuf;       // first three bytes of the current word, oldest in [7:0]
  logic [ADDR_W-1:0]   waddr;      // address the next completed word goes to
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum;       // running XOR of the payload bytes
`endif

  logic                accept;
  logic [16:0]         cnt_field;

  // A byte is taken whenever the source offers one and we are not in DONE.
  assign in_ready  = !rst && (state != DONE);
  assign accept    = in_valid && in_ready;
  assign cnt_field = {1'b0, in_data, cnt_lo};

  // Frame parser: one FSM register block driving all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_lo     <= 8'd0;
      word_tgt   <= 16'd0;
      word_cnt   <= 16'd0;
      byte_cnt   <= 2'd0;
      wbuf       <= 24'd0;
      waddr      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
      mem_we     <= 1'b0;
      mem_node   <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      cores_hold <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      // Strobes default low; they are raised for exactly one cycle below.
      mem_we    <= 1'b0;
      load_done <= 1'b0;

      if (state == DONE) begin
        // DONE consumes no byte; release the cores and report success.
        load_done  <= 1'b1;
        cores_hold <= 1'b0;
        state      <= IDLE;
      end else if (accept) begin
        case (state)
          IDLE: begin
            // Anything other than the header is line noise and is dropped.
            if (in_data == HDR_BYTE) begin
              state <= NODE;
            end
          end

          NODE: begin
            if ({1'b0, in_data} >= NODES_L) begin
              // Bad node: flag it but leave cores_hold as it was.
              load_err <= 1'b1;
              state    <= IDLE;
            end else begin
              mem_node   <= in_data[3:0];
              cores_hold <= 1'b1;
              load_err   <= 1'b0;
              state      <= CNT_LO;
            end
          end

          CNT_LO: begin
            cnt_lo <= in_data;
            state  <= CNT_HI;
          end

          CNT_HI: begin
            word_tgt <= {in_data, cnt_lo};
            word_cnt <= 16'd0;
            byte_cnt <= 2'd0;
            waddr    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
            if (cnt_field > SIZE_L) begin
              // Oversized load would overrun the node memory; refuse it whole.
              load_err <= 1'b1;
              state    <= IDLE;
            end else if (cnt_field == 17'd0) begin
              state <= PAYLOAD_END;
            end else begin
              state <= DATA;
            end
          end

          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            wbuf     <= {in_data, wbuf[23:8]};
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              // Fourth byte completes a little-endian word: write it out.
              mem_we    <= 1'b1;
              mem_addr  <= waddr;
              mem_wdata <= {in_data, wbuf};
              waddr     <= waddr + ADDR_W'(1);
              word_cnt  <= word_cnt + 16'd1;
              if (word_cnt + 16'd1 == word_tgt) begin
                state <= PAYLOAD_END;
              end
            end
          end

`ifdef LOADER_CHECKSUM_EN
          CSUM: begin
            if (in_data == csum) begin
              state <= DONE;
            end else begin
              // Words already written stay; cores remain held until a clean load.
              load_err <= 1'b1;
              state    <= IDLE;
            end
          end
`endif

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_rom_loader.sv
// Directed bench for sm_rom_loader: streams hand-built frames and checks writes and flags.
// Write strobes and load_done pulses are logged on the falling edge for later comparison.
// Build with or without LOADER_CHECKSUM_EN; checksum bytes are appended only when defined.
`timescale 1ns/1ps

`ifdef LOADER_CHECKSUM_EN
`define SEND_CSUM(b) send(b);
`else
`define SEND_CSUM(b)
`endif

module tb_sm_rom_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_node;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cores_hold;
  logic        load_done;
  logic        load_err;

  sm_rom_loader #(.SIZE(128), .ADDR_W(7), .NODES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_node   (mem_node),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cores_hold (cores_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  node;
    logic [6:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  last_done_cyc = 0;
  int  checks = 0;
  int  errors = 0;

`ifdef LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 2;
`else
  localparam int DONE_LAT = 1;
`endif

  // Log every write strobe and done pulse away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we === 1'b1) wq.push_back('{mem_node, mem_addr, mem_wdata, cyc});
    if (load_done === 1'b1) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare a logged write; a missing entry counts as a failure.
  task automatic chk_wr(input string tag, input int idx, input logic [3:0] node,
                        input logic [6:0] addr, input logic [31:0] data);
    if (idx >= wq.size()) begin
      checks++;
      errors++;
      $error("FAIL %s: write %0d missing, only %0d logged", tag, idx, wq.size());
    end else begin
      chk({tag, "_node"}, 32'(wq[idx].node), 32'(node));
      chk({tag, "_addr"}, 32'(wq[idx].addr), 32'(addr));
      chk({tag, "_data"}, wq[idx].data, data);
    end
  endtask

  // Offer one byte and hold it until the loader takes it (bounded wait).
  task automatic send(input logic [7:0] b);
    logic ok;
    int   n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $error("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference frame without its checksum: two words for the given node.
  task automatic send_frame(input logic [7:0] node);
    send(8'hA5); send(node); send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h50); send(8'h00);
    send(8'h63); send(8'h00); send(8'h00); send(8'h00);
  endtask

  int d0;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we), 32'd0);
    chk("rst_mem_node", 32'(mem_node), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata",    mem_wdata, 32'd0);
    chk("rst_hold",     32'(cores_hold), 32'd0);
    chk("rst_done",     32'(load_done), 32'd0);
    chk("rst_err",      32'(load_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Good two-word frame on node 3
    wq.delete(); d0 = done_cnt;
    send(8'hA5); send(8'h03);
    chk("t1_hold_rise", 32'(cores_hold), 32'd1);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h50); send(8'h00);
    send(8'h63); send(8'h00); send(8'h00); send(8'h00);
    `SEND_CSUM(8'h25)
    chk("t1_rdy_in_done", 32'(in_ready), 32'd0);
    idle(1);
    chk("t1_done_pulse", 32'(load_done), 32'd1);
    chk("t1_hold_fall",  32'(cores_hold), 32'd0);
    chk("t1_rdy_after",  32'(in_ready), 32'd1);
    idle(2);
    chk("t1_nwr", 32'(wq.size()), 32'd2);
    chk_wr("t1_w0", 0, 4'd3, 7'd0, 32'h00500513);
    chk_wr("t1_w1", 1, 4'd3, 7'd1, 32'h00000063);
    chk("t1_ndone", 32'(done_cnt - d0), 32'd1);
    chk("t1_err", 32'(load_err), 32'd0);
    if (wq.size() >= 2) chk("t1_done_lat", 32'(last_done_cyc - wq[1].cyc), 32'(DONE_LAT));

    // Zero-count frame: no writes, still completes
    wq.delete(); d0 = done_cnt;
    send(8'hA5); send(8'h04); send(8'h00); send(8'h00);
    `SEND_CSUM(8'h00)
    idle(3);
    chk("t2_nwr",   32'(wq.size()), 32'd0);
    chk("t2_ndone", 32'(done_cnt - d0), 32'd1);
    chk("t2_hold",  32'(cores_hold), 32'd0);

    // Count exactly SIZE: 128 words, payload XOR is zero
    wq.delete(); d0 = done_cnt;
    send(8'hA5); send(8'h05); send(8'h80); send(8'h00);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send(b); send(~b); send(b); send(~b);
    end
    `SEND_CSUM(8'h00)
    idle(3);
    chk("t3_nwr", 32'(wq.size()), 32'd128);
    chk_wr("t3_first", 0, 4'd5, 7'd0, 32'hFF00FF00);
    chk_wr("t3_last", 127, 4'd5, 7'd127, 32'h807F807F);
    chk("t3_ndone", 32'(done_cnt - d0), 32'd1);
    chk("t3_err", 32'(load_err), 32'd0);

    // Header value inside the payload is plain data
    wq.delete(); d0 = done_cnt;
    send(8'hA5); send(8'h02); send(8'h01); send(8'h00);
    send(8'hA5); send(8'hA5); send(8'h00); send(8'h01);
    `SEND_CSUM(8'h01)
    idle(3);
    chk("t4_nwr", 32'(wq.size()), 32'd1);
    chk_wr("t4_w0", 0, 4'd2, 7'd0, 32'h0100A5A5);
    chk("t4_ndone", 32'(done_cnt - d0), 32'd1);

    // Node out of range while idle-released: error, hold stays 0
    wq.delete(); d0 = done_cnt;
    send(8'hA5); send(8'h10);
    chk("t5_err", 32'(load_err), 32'd1);
    chk("t5_hold", 32'(cores_hold), 32'd0);

    // Count 129 > SIZE: node clears error, count sets it
    send(8'hA5); send(8'h01);
    chk("t6_err_clr", 32'(load_err), 32'd0);
    send(8'h81); send(8'h00);
    chk("t6_err_set", 32'(load_err), 32'd1);
    chk("t6_hold", 32'(cores_hold), 32'd1);

    // Bad node again: hold left untouched at 1
    send(8'hA5); send(8'h10);
    idle(2);
    chk("t7_hold", 32'(cores_hold), 32'd1);
    chk("t7_err", 32'(load_err), 32'd1);
    chk("t7_nwr", 32'(wq.size()), 32'd0);
    chk("t7_ndone", 32'(done_cnt - d0), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: writes land, error set, cores stay held
    wq.delete(); d0 = done_cnt;
    send_frame(8'h03); send(8'h24);
    chk("t8_err", 32'(load_err), 32'd1);
    idle(3);
    chk("t8_hold", 32'(cores_hold), 32'd1);
    chk("t8_nwr", 32'(wq.size()), 32'd2);
    chk("t8_ndone", 32'(done_cnt - d0), 32'd0);
`endif
    // Clean frame recovers error and hold
    wq.delete(); d0 = done_cnt;
    send_frame(8'h03);
    `SEND_CSUM(8'h25)
    idle(3);
    chk("t9_err", 32'(load_err), 32'd0);
    chk("t9_hold", 32'(cores_hold), 32'd0);
    chk("t9_ndone", 32'(done_cnt - d0), 32'd1);

    // Noise before the header is ignored
    wq.delete(); d0 = done_cnt;
    send(8'h00); send(8'hFF); send(8'h5A);
    idle(2);
    chk("t10_nwr", 32'(wq.size()), 32'd0);
    chk("t10_err", 32'(load_err), 32'd0);
    chk("t10_hold", 32'(cores_hold), 32'd0);
    send_frame(8'h07);
    `SEND_CSUM(8'h25)
    idle(3);
    chk_wr("t10_w0", 0, 4'd7, 7'd0, 32'h00500513);
    chk_wr("t10_w1", 1, 4'd7, 7'd1, 32'h00000063);
    chk("t10_ndone", 32'(done_cnt - d0), 32'd1);

    // Reset mid-word discards the partial frame
    wq.delete();
    send(8'hA5); send(8'h03); send(8'h02); send(8'h00); send(8'h13); send(8'h05);
    rst = 1'b1;
    #1;
    chk("t11_rdy", 32'(in_ready), 32'd0);
    chk("t11_hold", 32'(cores_hold), 32'd0);
    chk("t11_node", 32'(mem_node), 32'd0);
    chk("t11_we", 32'(mem_we), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("t11_nwr", 32'(wq.size()), 32'd0);
    send_frame(8'h03);
    `SEND_CSUM(8'h25)
    idle(3);
    chk("t11_nwr2", 32'(wq.size()), 32'd2);
    chk_wr("t11_w0", 0, 4'd3, 7'd0, 32'h00500513);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_rom_loader.md
# sm_rom_loader

Runtime instruction-memory writer for the multicore CPU array. It accepts a byte stream from a host link (UART receiver or debug bridge), parses load frames, and writes 32-bit instruction words into the instruction memory of the selected core node. It holds the cores in reset while a load is in progress. It sits between the host byte source and the per-node instruction memory write ports, and complements the read-only, initial-block memory image with in-system reprogramming.

## Interface
Parameters:
- SIZE, 128, instruction words per node memory; a load may not exceed this.
- ADDR_W, 7, width of mem_addr; must be ≥ clog2(SIZE).
- NODES, 16, number of addressable core nodes; valid node IDs are 0..NODES-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready
- mem_we  out  1  write strobe, one cycle per word
- mem_node  out  4  target node ID, valid with mem_we
- mem_addr  out  ADDR_W  word address, valid with mem_we
- mem_wdata  out  32  instruction word, valid with mem_we
- cores_hold  out  1  keep cores in reset while high
- load_done  out  1  one-cycle pulse on successful frame end
- load_err  out  1  sticky error flag

## Operation
- Frame layout: 0xA5 header, node ID byte, count low byte, count high byte, count×4 data bytes (little-endian words), then a checksum byte when LOADER_CHECKSUM_EN is defined.
- Checksum is the XOR of all data bytes only. When count=0 the expected checksum is 0x00.
- FSM states: IDLE, NODE, CNT_LO, CNT_HI, DATA, CSUM, DONE. Transitions occur on each accepted byte unless stated otherwise.
  - IDLE: 0xA5 → NODE. Any other byte is discarded silently.
  - NODE: if byte ≥ NODES, set load_err and go to IDLE. Otherwise latch the ID, set cores_hold, clear load_err, and go to CNT_LO.
  - CNT_LO → CNT_HI.
  - CNT_HI: if count > SIZE, set load_err and go to IDLE. If count = 0, go to CSUM (or DONE without the macro). Otherwise go to DATA.
  - DATA: a 2-bit byte counter assembles the word, with the first byte in [7:0]. On the 4th byte, issue a write and increment the address from 0. After the last word, go to CSUM (or DONE without the macro).
  - CSUM: on a match go to DONE. On a mismatch set load_err, keep cores_hold=1, and go to IDLE.
  - DONE: lasts exactly one cycle. in_ready=0, load_done=1, cores_hold cleared, then go to IDLE.
- Words already written in a frame that later fails are not rolled back. cores_hold stays 1 until a subsequent frame completes successfully.
- Widths:
  - The word counter is 16 bits and is compared against the count field.
  - mem_addr wraps modulo 2^ADDR_W, but it never reaches SIZE because of the count check.

## Timing
- Reset values: in_ready=0 while rst is high and 1 in the first cycle after release; mem_we=0, mem_node=0, mem_addr=0, mem_wdata=0, cores_hold=0, load_done=0, load_err=0; FSM in IDLE.
- in_ready=1 in every state except DONE. The block sustains one byte per cycle.
- mem_we, mem_addr, mem_wdata, and mem_node are registered. mem_we is high in the cycle after the 4th byte of a word is accepted, for exactly one cycle.
- cores_hold rises in the cycle after the node byte is accepted. It falls in the cycle after DONE.
- load_err is updated in the cycle after the offending byte is accepted.
- Reset asserted mid-frame: all state is cleared immediately, the partial word is discarded, and no further write is issued.
- A 0xA5 byte inside DATA or CNT fields is treated as data, not as a resync.

## Configuration
- LOADER_CHECKSUM_EN defined: the CSUM state and checksum byte are required; a mismatch sets load_err.
- LOADER_CHECKSUM_EN undefined: the CSUM state is removed. The frame ends after the last data byte (or after CNT_HI when count=0), and load_err is set only by node or count violations.

## Test plan
- Frame A5 03 02 00 13 05 50 00 63 00 00 00 25, streamed back-to-back → two writes on node 3: addr0 0x00500513, addr1 0x00000063. Then one load_done pulse, cores_hold back to 0, load_err=0.
- Same frame with checksum 0x24 → both writes occur, load_err=1, cores_hold stays 1, no load_done. Resending the correct frame → load_err=0 and cores_hold=0 after DONE.
- Bytes 00 FF 5A before a valid frame → no writes and no flags until 0xA5; the frame then loads normally.
- Frame A5 01 81 00 (count 129 > SIZE) → load_err=1 one cycle after CNT_HI, no mem_we, FSM in IDLE.
- Node byte 0x10 with NODES=16 → load_err=1, cores_hold unchanged, no writes.
- Reset pulse after the 2nd data byte of the first word → all outputs at reset values, no write. A following valid frame writes starting at addr 0.
- Build without LOADER_CHECKSUM_EN: first frame minus the trailing 0x25 → load_done in the cycle after the last write.
